// File: rtl/reaction_stimulus_ctrl.sv
// reaction_stimulus_ctrl: round controller for the reaction timer (fore-period, GO LED, timer start/stop, fault flags)
//   clk_1ms in 1 ms clock; reset in async active-high
//   btn_start in debounced level, rising edge arms a round; btn_react in debounced level, 1 = pressed
//   start/stop out timer pair (timer counts while start && !stop); led_go out stimulus LED
//   false_start/timeout out sticky fault flags; busy out high during fore-period and GO
//   RANDOM_DELAY_EN: when defined the fore-period gets an LFSR add-on, otherwise it is MIN_DELAY_MS
module reaction_stimulus_ctrl #(
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          RAND_BITS    = 11,
  parameter int          TIMEOUT_MS   = 9999,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic clk_1ms,
  input  logic reset,
  input  logic btn_start,
  input  logic btn_react,
  output logic start,
  output logic stop,
  output logic led_go,
  output logic false_start,
  output logic timeout,
  output logic busy
);
  typedef enum logic [2:0] {IDLE, DELAY, GO, DONE, FALSE, TMO} state_t;
  localparam logic [23:0] MIN_D   = 24'(MIN_DELAY_MS);
  localparam logic [23:0] GO_LAST = 24'(TIMEOUT_MS - 1);
  state_t      state, state_n;
  logic        btn_start_q, start_edge;
  logic [23:0] delay_cnt, delay_cnt_n, go_cnt, go_cnt_n, fore;
  assign start_edge = btn_start & ~btn_start_q;
`ifdef RANDOM_DELAY_EN
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;
  logic [15:0] lfsr;
  // Galois form of x^16+x^14+x^13+x^11+1; free-running so the add-on depends on when the button is hit
  always_ff @(posedge clk_1ms or posedge reset)
    if (reset) lfsr <= SEED;
    else lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign fore = MIN_D + 24'(lfsr[RAND_BITS-1:0]);
`else
  logic unused_cfg;
  assign unused_cfg = ^{LFSR_SEED, RAND_BITS};
  assign fore = MIN_D;
`endif
  always_ff @(posedge clk_1ms or posedge reset)
    if (reset) begin
      state       <= IDLE;
      btn_start_q <= 1'b0;
      delay_cnt   <= '0;
      go_cnt      <= '0;
    end else begin
      state       <= state_n;
      btn_start_q <= btn_start;
      delay_cnt   <= delay_cnt_n;
      go_cnt      <= go_cnt_n;
    end
  always_comb begin
    state_n     = state;
    delay_cnt_n = delay_cnt;
    go_cnt_n    = go_cnt;
    case (state)
      IDLE, DONE, FALSE, TMO: if (start_edge) begin
        state_n     = DELAY;
        delay_cnt_n = fore;
      end
      DELAY: if (btn_react) state_n = FALSE;
        else if (delay_cnt == 24'd1) begin
          state_n  = GO;
          go_cnt_n = '0;
        end else delay_cnt_n = delay_cnt - 24'd1;
      GO: begin
        go_cnt_n = go_cnt + 24'd1;
        // a press in the last GO cycle still counts as a reaction
        state_n  = btn_react ? DONE : (go_cnt == GO_LAST) ? TMO : GO;
      end
      default: state_n = IDLE;
    endcase
  end
  assign busy        = (state == DELAY) || (state == GO);
  assign led_go      = (state == GO);
  assign start       = (state == GO) || (state == DONE) || (state == TMO);
  assign stop        = (state == DONE) || (state == FALSE) || (state == TMO);
  assign false_start = (state == FALSE);
  assign timeout     = (state == TMO);
endmodule
